load_store_unit: RTL

- Sits directly upstream of the 64-bit, 32-entry word-addressed data memory.
- Accepts byte-addressed load/store requests from the execute stage over a valid/ready handshake.
- Performs B/H/W/D sizing, alignment checking, read-modify-write for sub-doubleword stores, and sign/zero extension of loads.
- Returns one response per request to the writeback stage.

---
 rtl/lsu_pkg.sv | 23 ++
 rtl/lsu_lane_align.sv | 46 ++++
 rtl/load_store_unit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the size-to-byte-count helper.
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2,
      SZ_D = 2'd3
   } size_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      RESP = 2'd3
   } state_e;

   function automatic logic [3:0] size_bytes(input size_e size);
      return 4'd1 << size;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: extracts and extends a load lane from a memory
// word, and merges store data into a memory word at the addressed lane.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [63:0] word,
   input  logic [2:0]  offset,
   input  size_e       size,
   input  logic        is_signed,
   input  logic [63:0] wdata,
   output logic [63:0] load_data,
   output logic [63:0] merged_word
);

   logic [5:0]  shamt;
   logic [63:0] lane;
   logic [63:0] size_mask;

   assign shamt = {offset, 3'b000};

   always_comb begin
      lane      = word >> shamt;
      size_mask = '1;
      load_data = lane;
      case (size)
         SZ_B: begin
            size_mask = 64'h0000_0000_0000_00FF;
            load_data = {{56{is_signed & lane[7]}}, lane[7:0]};
         end
         SZ_H: begin
            size_mask = 64'h0000_0000_0000_FFFF;
            load_data = {{48{is_signed & lane[15]}}, lane[15:0]};
         end
         SZ_W: begin
            size_mask = 64'h0000_0000_FFFF_FFFF;
            load_data = {{32{is_signed & lane[31]}}, lane[31:0]};
         end
         default: begin
            size_mask = '1;
            load_data = lane;
         end
      endcase
      merged_word = (word & ~(size_mask << shamt)) | ((wdata & size_mask) << shamt);
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit in front of a word-addressed 64-bit data memory: sizing,
// alignment/range checking, read-modify-write stores and load extension.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_DEPTH  = 32,
   parameter int unsigned MEM_RD_LAT = 1
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        ReqValid,
   output logic        ReqReady,
   input  logic        ReqWrite,
   input  logic [1:0]  ReqSize,
   input  logic        ReqSigned,
   input  logic [63:0] ReqAddr,
   input  logic [63:0] ReqWData,
   output logic        RespValid,
   input  logic        RespReady,
   output logic [63:0] RespRData,
   output logic        RespError,
   output logic [63:0] MemAddress,
   output logic [63:0] MemDataIn,
   output logic        MemWrite,
   output logic        MemRead,
   input  logic [63:0] MemDataOut
);

   localparam int unsigned      CNT_W      = $clog2(MEM_RD_LAT + 2);
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(MEM_RD_LAT);
   localparam logic [63:0]      ADDR_LIMIT = 64'(MEM_DEPTH) * 64'd8;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [63:0]      addr_q, addr_d;
   logic [63:0]      wdata_q, wdata_d;
   logic [63:0]      merged_q, merged_d;
   logic [63:0]      rdata_q, rdata_d;
   size_e            size_q, size_d;
   logic             write_q, write_d;
   logic             signed_q, signed_d;
   logic             err_q, err_d;
   logic             ready_q, ready_d;

   size_e       req_size;
   logic        misaligned;
   logic        out_of_range;
   logic [63:0] load_data;
   logic [63:0] merged_word;

   assign req_size     = size_e'(ReqSize);
   assign misaligned   = (ReqAddr[2:0] & 3'(size_bytes(req_size) - 4'd1)) != 3'd0;
   assign out_of_range = ReqAddr >= ADDR_LIMIT;

   lsu_lane_align u_lane_align (
      .word        (MemDataOut),
      .offset      (addr_q[2:0]),
      .size        (size_q),
      .is_signed   (signed_q),
      .wdata       (wdata_q),
      .load_data   (load_data),
      .merged_word (merged_word)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      merged_d = merged_q;
      rdata_d  = rdata_q;
      size_d   = size_q;
      write_d  = write_q;
      signed_d = signed_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            if (ReqValid && ready_q) begin
               addr_d   = ReqAddr;
               wdata_d  = ReqWData;
               size_d   = req_size;
               write_d  = ReqWrite;
               signed_d = ReqSigned;
               cnt_d    = '0;
               rdata_d  = '0;
               merged_d = ReqWData;
               err_d    = misaligned || out_of_range;
               if (misaligned || out_of_range) begin
                  state_d = RESP;
               end else if (ReqWrite && (req_size == SZ_D)) begin
                  state_d = WR;
               end else begin
                  state_d = RD;
               end
            end
         end
         RD: begin
            // Memory data is valid on the final counted edge only.
            if (cnt_q == CNT_LAST) begin
               if (write_q) begin
                  merged_d = merged_word;
                  state_d  = WR;
               end else begin
                  rdata_d  = load_data;
                  state_d  = RESP;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WR: begin
            state_d = RESP;
         end
         RESP: begin
            if (RespReady) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         merged_q <= '0;
         rdata_q  <= '0;
         size_q   <= SZ_B;
         write_q  <= 1'b0;
         signed_q <= 1'b0;
         err_q    <= 1'b0;
         ready_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         merged_q <= merged_d;
         rdata_q  <= rdata_d;
         size_q   <= size_d;
         write_q  <= write_d;
         signed_q <= signed_d;
         err_q    <= err_d;
         ready_q  <= ready_d;
      end
   end

   assign ReqReady   = ready_q;
   assign RespValid  = (state_q == RESP);
   assign RespRData  = rdata_q;
   assign RespError  = err_q;
   assign MemAddress = {3'b000, addr_q[63:3]};
   assign MemDataIn  = merged_q;
   assign MemWrite   = (state_q == WR);
   assign MemRead    = (state_q == RD);

endmodule
